// File: rtl/fft_twiddle_mul32.sv
`default_nettype none
// ============================================================================
// Module      : fft_twiddle_mul32
// Description : Twiddle multiplier for the PUSCH FFT. Tracks each sample's
//               index n (0..31) within a frame, addresses an external 32-entry
//               twiddle ROM with (n*STEP) mod 32 and multiplies the sample by
//               the returned twiddle (Q10, 1.0 = 1024). Fixed 3-cycle latency.
// Ports       : clk, rst_n            clock, async active-low reset
//               in_valid/in_sof       sample qualifier / start of frame
//               in_re/in_im           input sample (signed WIDTH)
//               tw_addr               twiddle ROM address
//               tw_re/tw_im           twiddle from ROM (signed 18)
//               out_valid/out_sof     delayed qualifiers
//               out_re/out_im         rounded, saturated product
//               sat_cnt               saturation event counter (optional)
// Options     : define TWMUL_SAT_CNT_EN to add the sat_cnt port and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_mul32 #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int TW_FF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic [4:0]       tw_addr,
  input  logic [17:0]      tw_re,
  input  logic [17:0]      tw_im,
  output logic             out_valid,
  output logic             out_sof,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
`ifdef TWMUL_SAT_CNT_EN
  ,
  output logic [7:0]       sat_cnt
`endif
);

  localparam int c_pw = WIDTH + 18;
  localparam int c_sw = WIDTH + 19;
  localparam logic signed [c_sw-1:0] c_round = c_sw'(512);
  localparam logic signed [c_sw-1:0] c_max   = {{(c_sw-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [c_sw-1:0] c_min   = ~c_max;

  // Returns {clamped_flag, clamped_value}
  function automatic logic [WIDTH:0] sat_fn(input logic signed [c_sw-1:0] v);
    if (v > c_max)      return {1'b1, c_max[WIDTH-1:0]};
    else if (v < c_min) return {1'b1, c_min[WIDTH-1:0]};
    else                return {1'b0, v[WIDTH-1:0]};
  endfunction

  logic [4:0]              n_q, n_d, idx;
  logic                    a_valid_q, a_valid_d, a_sof_q, a_sof_d;
  logic signed [WIDTH-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
  logic                    b_valid_q, b_valid_d, b_sof_q, b_sof_d;
  logic signed [c_pw-1:0]  ac_q, ac_d, bd_q, bd_d, ad_q, ad_d, bc_q, bc_d;
  logic signed [c_sw-1:0]  sum_re, sum_im;
  logic [WIDTH:0]          sat_re, sat_im;
  logic                    out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic [WIDTH-1:0]        out_re_q, out_re_d, out_im_q, out_im_d;
  logic signed [17:0]      tw_c, tw_d;

  // Twiddle alignment: a registered ROM already lines up with stage A, a
  // combinational ROM is captured into stage A alongside the data.
  generate
    if (TW_FF == 0) begin : g_tw_reg
      logic [17:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;
      always_comb begin
        tw_re_d = tw_re;
        tw_im_d = tw_im;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tw_re_q <= '0;
          tw_im_q <= '0;
        end else begin
          tw_re_q <= tw_re_d;
          tw_im_q <= tw_im_d;
        end
      end
      assign tw_c = tw_re_q;
      assign tw_d = tw_im_q;
    end else begin : g_tw_direct
      assign tw_c = tw_re;
      assign tw_d = tw_im;
    end
  endgenerate

  always_comb begin
    // A start of frame restarts indexing on that very sample
    idx = n_q;
    if (in_valid && in_sof) idx = '0;
    n_d = n_q;
    if (in_valid) n_d = idx + 5'd1;
    tw_addr = idx * 5'(STEP);

    a_valid_d = in_valid;
    a_sof_d   = in_valid & in_sof;
    a_re_d    = in_re;
    a_im_d    = in_im;

    b_valid_d = a_valid_q;
    b_sof_d   = a_sof_q;
    ac_d      = c_pw'(a_re_q) * c_pw'(tw_c);
    bd_d      = c_pw'(a_im_q) * c_pw'(tw_d);
    ad_d      = c_pw'(a_re_q) * c_pw'(tw_d);
    bc_d      = c_pw'(a_im_q) * c_pw'(tw_c);

    sum_re = c_sw'(ac_q) - c_sw'(bd_q) + c_round;
    sum_im = c_sw'(ad_q) + c_sw'(bc_q) + c_round;
    sat_re = sat_fn(sum_re >>> 10);
    sat_im = sat_fn(sum_im >>> 10);

    out_valid_d = b_valid_q;
    out_sof_d   = b_sof_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (b_valid_q) begin
      out_re_d = sat_re[WIDTH-1:0];
      out_im_d = sat_im[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q         <= '0;
      a_valid_q   <= 1'b0;
      a_sof_q     <= 1'b0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_valid_q   <= 1'b0;
      b_sof_q     <= 1'b0;
      ac_q        <= '0;
      bd_q        <= '0;
      ad_q        <= '0;
      bc_q        <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      n_q         <= n_d;
      a_valid_q   <= a_valid_d;
      a_sof_q     <= a_sof_d;
      a_re_q      <= a_re_d;
      a_im_q      <= a_im_d;
      b_valid_q   <= b_valid_d;
      b_sof_q     <= b_sof_d;
      ac_q        <= ac_d;
      bd_q        <= bd_d;
      ad_q        <= ad_d;
      bc_q        <= bc_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

`ifdef TWMUL_SAT_CNT_EN
  logic [7:0] sat_cnt_q, sat_cnt_d;

  // Counts clamped outputs, sticking at 255
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (b_valid_q && (sat_re[WIDTH] || sat_im[WIDTH]) && (sat_cnt_q != 8'hFF))
      sat_cnt_d = sat_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_sat_flags;
  assign unused_sat_flags = sat_re[WIDTH] ^ sat_im[WIDTH];
`endif

endmodule
`default_nettype wire
